// File: rtl/vec_elem_serializer.sv
// vec_elem_serializer: unpacks a masked vector into ascending per-lane element writes
module vec_elem_serializer #(
  parameter int VECTOR_SIZE = 256,
  parameter int ELEMENT = 16,
  parameter int ADDR_W = 16,
  localparam int LANES = VECTOR_SIZE / ELEMENT,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VECTOR_SIZE-1:0] in_vector,
  input  logic [ADDR_W-1:0]      in_base_addr,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ELEMENT-1:0]     out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_last,
  output logic                   busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic [0:0]             state_q, state_d;
  logic [VECTOR_SIZE-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [LANES-1:0]       low, rest;
  logic [LW-1:0]          lane;
  logic                   send, fire, last, accept;
  // mask_q holds only the lanes still to be emitted; its lowest set bit is the current lane
  always_comb begin
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (mask_q[i]) lane = LW'(i);
    low = mask_q & (~mask_q + 1'b1);
    rest = mask_q & ~low;
    last = rest == '0;
    send = state_q == SEND;
    fire = send & out_ready;
    in_ready = (state_q == IDLE) & ~rst;
    accept = in_valid & in_ready;
    state_d = accept ? ((|in_mask) ? SEND : IDLE) : (fire & last) ? IDLE : state_q;
    mask_d = accept ? in_mask : fire ? rest : mask_q;
    vec_d = accept ? in_vector : vec_q;
    base_d = accept ? in_base_addr : base_q;
    out_valid = send;
    out_data = send ? vec_q[lane*ELEMENT +: ELEMENT] : '0;
    out_addr = send ? base_q + ADDR_W'(lane) : '0;
    out_last = send & last;
    busy = send;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      base_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      base_q <= base_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: tb/tb_vec_elem_serializer.sv
// tb_vec_elem_serializer: randomized and directed checks against a beat-queue model
module tb_vec_elem_serializer;
  logic         clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic         in_ready, out_valid, out_last, busy;
  logic [255:0] in_vector = '0;
  logic [15:0]  in_base_addr = '0, in_mask = '0;
  logic [15:0]  out_data, out_addr;
  typedef struct packed {logic [15:0] data; logic [15:0] addr; logic last; int cyc;} beat_t;
  beat_t q[$], log_q[$];
  int acc_cyc[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, mode = 0, ph = 0;
  bit exp_v;
  vec_elem_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vector(in_vector), .in_base_addr(in_base_addr), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // model: an accepted vector becomes the list of beats for its enabled lanes, ascending
  task automatic expand(input logic [255:0] v, input logic [15:0] b, input logic [15:0] m);
    int hi = -1;
    beat_t e;
    for (int i = 0; i < 16; i++) if (m[i]) hi = i;
    for (int i = 0; i < 16; i++)
      if (m[i]) begin
        e.data = v[i*16 +: 16];
        e.addr = b + 16'(i);
        e.last = (i == hi);
        e.cyc = 0;
        q.push_back(e);
      end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (rst) q.delete();
    else begin
      exp_v = q.size() != 0;
      cmp("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      cmp("in_ready", {31'b0, in_ready}, {31'b0, !exp_v});
      cmp("busy", {31'b0, busy}, {31'b0, exp_v});
      if (exp_v) begin
        cmp("out_data", {16'b0, out_data}, {16'b0, q[0].data});
        cmp("out_addr", {16'b0, out_addr}, {16'b0, q[0].addr});
        cmp("out_last", {31'b0, out_last}, {31'b0, q[0].last});
        if (out_ready) begin
          log_q.push_back(beat_t'{data: q[0].data, addr: q[0].addr, last: q[0].last, cyc: cyc});
          q.pop_front();
        end
      end
      if (in_valid && !exp_v) begin
        acc_cyc.push_back(cyc);
        expand(in_vector, in_base_addr, in_mask);
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mode == 0) out_ready = 1;
      else if (mode == 1) begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
      else out_ready = 1'($urandom_range(0, 1));
    end
  end
  task automatic send_vec(input logic [255:0] v, input logic [15:0] b, input logic [15:0] m);
    bit acc = 0;
    int n = 0;
    in_valid = 1; in_vector = v; in_base_addr = b; in_mask = m;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    in_valid = 0;
    if (!acc) cmp("accept_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); #1; n++; end while ((q.size() != 0 || busy) && n < 300);
    if (n >= 300) cmp("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask
  function automatic logic [255:0] ramp(input logic [15:0] start);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = start + 16'(i);
    return v;
  endfunction
  initial begin
    int n;
    logic [255:0] rv;
    logic [15:0] rm;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("in_ready_in_rst", {31'b0, in_ready}, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    cmp("rst_out_valid", {31'b0, out_valid}, 0);
    cmp("rst_out_last", {31'b0, out_last}, 0);
    cmp("rst_out_data", {16'b0, out_data}, 0);
    cmp("rst_out_addr", {16'b0, out_addr}, 0);
    cmp("rst_busy", {31'b0, busy}, 0);
    cmp("rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    log_q.delete();
    send_vec(ramp(16'h1000), 16'h0040, 16'hFFFF);
    wait_idle();
    cmp("t1_count", log_q.size(), 16);
    cmp("t1_first_addr", {16'b0, log_q[0].addr}, 32'h40);
    cmp("t1_first_data", {16'b0, log_q[0].data}, 32'h1000);
    cmp("t1_last_addr", {16'b0, log_q[15].addr}, 32'h4F);
    cmp("t1_last_flag", {31'b0, log_q[15].last}, 1);
    cmp("t1_back_to_back", log_q[15].cyc - log_q[0].cyc, 15);
    log_q.delete();
    send_vec(ramp(16'h2000), 16'h0000, 16'h8001);
    wait_idle();
    cmp("t2_count", log_q.size(), 2);
    cmp("t2_addr0", {16'b0, log_q[0].addr}, 0);
    cmp("t2_addr1", {16'b0, log_q[1].addr}, 32'hF);
    cmp("t2_last0", {31'b0, log_q[0].last}, 0);
    cmp("t2_last1", {31'b0, log_q[1].last}, 1);
    log_q.delete();
    send_vec(ramp(16'h3000), 16'hFFFE, 16'h000F);
    wait_idle();
    cmp("t3_count", log_q.size(), 4);
    cmp("t3_a0", {16'b0, log_q[0].addr}, 32'hFFFE);
    cmp("t3_a1", {16'b0, log_q[1].addr}, 32'hFFFF);
    cmp("t3_a2", {16'b0, log_q[2].addr}, 32'h0000);
    cmp("t3_a3", {16'b0, log_q[3].addr}, 32'h0001);
    log_q.delete();
    mode = 1; ph = 0;
    send_vec(ramp(16'h4000), 16'h0000, 16'hFFFF);
    wait_idle();
    mode = 0;
    cmp("t4_count", log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) cmp("t4_order", {16'b0, log_q[i].addr}, i);
    log_q.delete(); acc_cyc.delete();
    send_vec(ramp(16'h5000), 16'h0000, 16'h0000);
    send_vec(ramp(16'h6000), 16'h0100, 16'h0030);
    wait_idle();
    cmp("t5_accept_gap", acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : 0, 1);
    cmp("t5_count", log_q.size(), 2);
    cmp("t5_addr", {16'b0, log_q[0].addr}, 32'h0104);
    log_q.delete();
    send_vec(ramp(16'h7000), 16'h0000, 16'hFFFF);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (log_q.size() < 5 && n < 100);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    cmp("t6_out_valid", {31'b0, out_valid}, 0);
    cmp("t6_in_ready", {31'b0, in_ready}, 1);
    cmp("t6_beats_before_rst", log_q.size(), 5);
    @(posedge clk); #1;
    log_q.delete();
    send_vec(ramp(16'h8000), 16'h0000, 16'h0F00);
    wait_idle();
    cmp("t6_restart_addr", {16'b0, log_q[0].addr}, 8);
    cmp("t6_restart_data", {16'b0, log_q[0].data}, 32'h8008);
    mode = 2;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 8; i++) rv[i*32 +: 32] = $urandom;
      rm = (k % 10 == 3) ? 16'h0 : (k % 10 == 7) ? 16'hFFFF : 16'($urandom);
      send_vec(rv, 16'($urandom), rm);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
